// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between NUM_REQ byte sources,
// plus an independent receive-byte capture path that clears dataReceived.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [7:0]           uart_tx_data,
    output logic                 uart_tx_request,
    input  logic                 uart_tx_active,
    input  logic                 uart_data_received,
    input  logic [7:0]           uart_rx_data,
    output logic                 uart_clear_dr,
    output logic [7:0]           rx_byte,
    output logic                 rx_valid,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, REQUEST, ACTIVE, DONE} state_t;

    state_t          state;
    logic [GW-1:0]   gnt_idx;
    logic [GW-1:0]   last_grant;
    logic [CW-1:0]   cnt;

    logic            pick_found;
    logic [GW-1:0]   pick_idx;
    logic [GW-1:0]   cand;
    logic [7:0]      pick_data;

    // Search upward from the requester after the last one served, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((int'(last_grant) + k) % NUM_REQ);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == pick_idx) pick_data = req_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            gnt_idx         <= '0;
            last_grant      <= GW'(NUM_REQ - 1);
            cnt             <= '0;
            uart_tx_data    <= '0;
            uart_tx_request <= 1'b0;
            req_ack         <= '0;
            busy            <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            req_ack     <= '0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        gnt_idx         <= pick_idx;
                        uart_tx_data    <= pick_data;
                        uart_tx_request <= 1'b1;
                        cnt             <= '0;
                        busy            <= 1'b1;
                        state           <= REQUEST;
                    end
                end
                REQUEST: begin
                    if (uart_tx_active) begin
                        uart_tx_request <= 1'b0;
                        state           <= ACTIVE;
                    end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        // Abort: the requester gets no ack and loses its turn.
                        uart_tx_request <= 1'b0;
                        timeout_err     <= 1'b1;
                        last_grant      <= gnt_idx;
                        busy            <= 1'b0;
                        state           <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ACTIVE: begin
                    if (!uart_tx_active) begin
                        req_ack <= NUM_REQ'(1) << gnt_idx;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    last_grant <= gnt_idx;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Receive side: one capture per dataReceived assertion, held off by clearDR.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_byte       <= '0;
            rx_valid      <= 1'b0;
            uart_clear_dr <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (uart_data_received && !uart_clear_dr) begin
                rx_byte       <= uart_rx_data;
                rx_valid      <= 1'b1;
                uart_clear_dr <= 1'b1;
            end else if (uart_clear_dr && !uart_data_received) begin
                uart_clear_dr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple UART transmitter model.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] req_data;
    logic [1:0]  req_ack;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_request;
    logic        uart_tx_active;
    logic        uart_data_received;
    logic [7:0]  uart_rx_data;
    logic        uart_clear_dr;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        busy;
    logic        timeout_err;

    uart_tx_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_ack(req_ack),
        .uart_tx_data(uart_tx_data), .uart_tx_request(uart_tx_request),
        .uart_tx_active(uart_tx_active), .uart_data_received(uart_data_received),
        .uart_rx_data(uart_rx_data), .uart_clear_dr(uart_clear_dr),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int ack_cnt [2];
    int ack_log [$];
    logic [7:0] sent [$];
    int last_ack_cyc, fall_cyc, rx_cnt;
    logic model_en;
    int dly, hold;

    always @(posedge clk) cyc <= cyc + 1;

    // UART model: txActive rises 3 cycles after txRequest and stays up 20 cycles.
    always @(negedge clk) begin
        if (!model_en) begin
            uart_tx_active = 1'b0;
            dly = 0;
            hold = 0;
        end else if (hold > 0) begin
            hold--;
            if (hold == 0) begin
                uart_tx_active = 1'b0;
                fall_cyc = cyc;
            end
        end else if (uart_tx_request && !uart_tx_active) begin
            dly++;
            if (dly == 3) begin
                uart_tx_active = 1'b1;
                hold = 20;
                dly = 0;
                sent.push_back(uart_tx_data);
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (req_ack[i]) begin
                ack_cnt[i]++;
                ack_log.push_back(i);
                last_ack_cyc = cyc;
            end
        end
        if (rx_valid) rx_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input logic en);
        @(negedge clk);
        reset = 1'b0;
        model_en = 1'b0;
        req = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_en = en;
        sent.delete();
        ack_log.delete();
    endtask

    task automatic wait_ack(input int idx, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (req_ack[idx]) ok = 1'b1;
        end
    endtask

    task automatic wait_active(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (uart_tx_active) ok = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int t0, a0, a1, r0;
        ack_cnt[0] = 0; ack_cnt[1] = 0; rx_cnt = 0;
        last_ack_cyc = 0; fall_cyc = 0;
        reset = 1'b0; model_en = 1'b0; req = 2'b00; req_data = '0;
        uart_data_received = 1'b0; uart_rx_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", {22'd0, req_ack, uart_tx_request, uart_tx_data}, 32'h0);
        chk("rst_rx", {23'd0, uart_clear_dr, rx_byte}, 32'h0);
        chk("rst_ctl", {30'd0, rx_valid, busy}, 32'h0);
        chk("rst_to", timeout_err, 1'b0);

        // Single byte from requester 0
        reset = 1'b1; model_en = 1'b1;
        req = 2'b01; req_data = 16'h00A5;
        @(negedge clk);
        chk("single_req", uart_tx_request, 1'b1);
        chk("single_data", uart_tx_data, 8'hA5);
        chk("single_busy", busy, 1'b1);
        wait_ack(0, 100, ok);
        chk("single_ack_seen", ok, 1'b1);
        chk("single_req_low", uart_tx_request, 1'b0);
        chk("single_ack_only0", req_ack, 2'b01);
        req = 2'b00;
        repeat (3) @(negedge clk);
        chk("single_ack_lat", last_ack_cyc - fall_cyc, 1);
        chk("single_sent", sent.size() > 0 ? sent[0] : 8'hxx, 8'hA5);
        chk("single_ack_cnt", ack_cnt[0], 1);
        chk("single_idle", busy, 1'b0);

        // Round-robin with both requesters held
        do_reset(1'b1);
        req = 2'b11; req_data = 16'h2211;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (ack_log.size() >= 4) ok = 1'b1;
        end
        req = 2'b00;
        chk("rr_done", ok, 1'b1);
        if (ok) begin
            chk("rr_b0", sent[0], 8'h11);
            chk("rr_b1", sent[1], 8'h22);
            chk("rr_b2", sent[2], 8'h11);
            chk("rr_b3", sent[3], 8'h22);
            chk("rr_ack_order", {ack_log[0][7:0], ack_log[1][7:0], ack_log[2][7:0], ack_log[3][7:0]}, 32'h00010001);
        end

        // Handshake timeout, then requester 0 granted next
        do_reset(1'b0);
        a0 = ack_cnt[0]; a1 = ack_cnt[1];
        req = 2'b10; req_data = 16'h7755;
        @(negedge clk);
        chk("to_req", uart_tx_request, 1'b1);
        chk("to_data", uart_tx_data, 8'h77);
        t0 = cyc;
        req = 2'b11;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (timeout_err) ok = 1'b1;
        end
        chk("to_seen", ok, 1'b1);
        chk("to_latency", cyc - t0, 8);
        chk("to_req_low", uart_tx_request, 1'b0);
        chk("to_idle", busy, 1'b0);
        @(negedge clk);
        chk("to_pulse", timeout_err, 1'b0);
        chk("to_next_req", uart_tx_request, 1'b1);
        chk("to_next_data", uart_tx_data, 8'h55);
        do_reset(1'b1);
        @(negedge clk);
        chk("to_no_ack", {ack_cnt[1][15:0], ack_cnt[0][15:0]}, {a1[15:0], a0[15:0]});

        // RX capture concurrent with a transfer
        a0 = ack_cnt[0]; r0 = rx_cnt;
        req = 2'b01; req_data = 16'h005A;
        repeat (2) @(negedge clk);
        uart_rx_data = 8'h3C; uart_data_received = 1'b1;
        repeat (3) @(negedge clk);
        chk("rx_clear_high", uart_clear_dr, 1'b1);
        @(negedge clk);
        uart_data_received = 1'b0;
        @(negedge clk);
        uart_rx_data = 8'hFF;
        chk("rx_clear_low", uart_clear_dr, 1'b0);
        chk("rx_byte", rx_byte, 8'h3C);
        wait_ack(0, 100, ok);
        chk("rx_tx_ack", ok, 1'b1);
        req = 2'b00;
        repeat (3) @(negedge clk);
        chk("rx_once", rx_cnt - r0, 1);
        chk("rx_byte_kept", rx_byte, 8'h3C);
        chk("rx_tx_sent", sent.size() > 0 ? sent[0] : 8'hxx, 8'h5A);
        chk("rx_tx_ack_cnt", ack_cnt[0] - a0, 1);

        // Reset while ACTIVE
        do_reset(1'b1);
        a0 = ack_cnt[0];
        req = 2'b01; req_data = 16'h0099;
        wait_active(50, ok);
        chk("mid_active", ok, 1'b1);
        repeat (2) @(negedge clk);
        chk("mid_busy", busy, 1'b1);
        reset = 1'b0; model_en = 1'b0;
        @(negedge clk);
        chk("mid_req_low", uart_tx_request, 1'b0);
        chk("mid_busy_low", busy, 1'b0);
        chk("mid_no_ack", req_ack, 2'b00);
        reset = 1'b1;
        req = 2'b11; req_data = 16'h3412;
        @(negedge clk);
        chk("mid_regrant_req", uart_tx_request, 1'b1);
        chk("mid_regrant_data", uart_tx_data, 8'h12);
        repeat (3) @(negedge clk);
        chk("mid_ack_cnt", ack_cnt[0] - a0, 0);

        // Requester drops req during ACTIVE
        do_reset(1'b1);
        a0 = ack_cnt[0];
        req = 2'b01; req_data = 16'h006B;
        wait_active(50, ok);
        chk("drop_active", ok, 1'b1);
        @(negedge clk);
        req = 2'b00;
        wait_ack(0, 100, ok);
        chk("drop_ack", ok, 1'b1);
        repeat (4) @(negedge clk);
        chk("drop_ack_cnt", ack_cnt[0] - a0, 1);
        chk("drop_sent", sent.size() > 0 ? sent[0] : 8'hxx, 8'h6B);
        chk("drop_idle", {30'd0, uart_tx_request, busy}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte sources using round-robin arbitration.
- Sequences the UART txRequest/txActive handshake for each granted byte.
- Independently services the receiver: captures each received byte, then clears dataReceived through clearDR.
- Sits between the UART instance and its byte producers (echo path, program result path) in the top level.

Parameters:
NUM_REQ, 2, number of transmit requesters (2..8)
TIMEOUT_CYCLES, 1024, cycles to wait in REQUEST for txActive before aborting (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
req  input  NUM_REQ  per-requester "byte pending"; must stay high with stable data until matching ack
req_data  input  8*NUM_REQ  byte for requester i in bits [8i+7:8i]
req_ack  output  NUM_REQ  one-cycle pulse: requester i's byte fully transmitted
uart_tx_data  output  8  to UART txData
uart_tx_request  output  1  to UART txRequest
uart_tx_active  input  1  from UART txActive
uart_data_received  input  1  from UART dataReceived
uart_rx_data  input  8  from UART rxData
uart_clear_dr  output  1  to UART clearDR
rx_byte  output  8  last captured received byte
rx_valid  output  1  one-cycle pulse when rx_byte updates
busy  output  1  high whenever TX FSM is not IDLE
timeout_err  output  1  one-cycle pulse on TX handshake abort

Behaviour:
- Reset (reset==0 at a clk edge):
  - All outputs go to 0 and the TX FSM goes to IDLE.
  - last_grant is set to NUM_REQ-1, so requester 0 has first priority.
  - Reset takes effect mid-transfer too: uart_tx_request drops, no ack is issued, and the interrupted byte is lost.
- TX FSM states: IDLE, REQUEST, ACTIVE, DONE.
- IDLE:
  - If any req bit is high, grant the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - On the grant edge: latch the index into gnt_idx, latch req_data[gnt_idx] into uart_tx_data, set uart_tx_request=1, clear the timeout counter, go to REQUEST.
  - The grant decision is registered; uart_tx_request is high one cycle after req is first seen.
- REQUEST:
  - Hold uart_tx_request=1 and uart_tx_data stable.
  - If uart_tx_active==1: uart_tx_request<=0, go to ACTIVE.
  - Otherwise increment the counter. When it reaches TIMEOUT_CYCLES-1: uart_tx_request<=0, timeout_err pulses, last_grant<=gnt_idx, go to IDLE. No ack is issued in this case.
- ACTIVE:
  - Wait for uart_tx_active==0, then go to DONE.
  - No timeout applies in ACTIVE.
- DONE:
  - req_ack[gnt_idx] pulses for exactly one cycle and last_grant<=gnt_idx, then go to IDLE.
  - A requester sampling its ack may present a new byte the following cycle.
- uart_tx_data changes only on the IDLE grant edge.
- Requester dropping req after grant: the transfer still completes and the ack still pulses. Requesters must ignore acks they did not expect.
- Fairness: a requester holding req continuously waits at most NUM_REQ-1 other transfers.
- Minimum spacing between grants is one IDLE cycle after DONE.
- RX path (independent, runs concurrently with TX):
  - Trigger condition: uart_data_received==1 and uart_clear_dr==0.
  - On trigger: rx_byte<=uart_rx_data, rx_valid pulses one cycle, uart_clear_dr<=1.
  - uart_clear_dr stays high until uart_data_received is sampled low, then drops the next cycle.
  - No capture occurs while uart_clear_dr is high, so each received byte produces exactly one rx_valid.
- busy = (state != IDLE), registered.

Test Plan:
- Single byte: after reset release, req=2'b01, req_data[7:0]=8'hA5; UART model raises txActive 3 cycles after txRequest and holds it 20 cycles. Expect: uart_tx_data=A5, uart_tx_request high until txActive, req_ack[0] one-cycle pulse exactly one cycle after txActive falls.
- Round-robin: req=2'b11 held, bytes 8'h11/8'h22. Expect transmit order 11,22,11,22, with ack[0] and ack[1] alternating.
- Timeout: TIMEOUT_CYCLES=8, txActive held 0, req[1]=1. Expect timeout_err pulse 8 cycles after uart_tx_request rises, uart_tx_request=0, no ack, FSM IDLE. With req[0] also high, requester 0 is granted next.
- RX capture: dataReceived rises with rxData=8'h3C and stays high 4 cycles. Expect exactly one rx_valid with rx_byte=3C, and uart_clear_dr high until dataReceived falls. Run concurrently with an active TX transfer; the transfer must be unaffected.
- Reset mid-operation: assert reset=0 during ACTIVE. Expect next-edge uart_tx_request=0, busy=0, no ack, and after release requester 0 is granted first.
- Early req drop: req[0] deasserted in ACTIVE. Expect the byte still completes and ack[0] still pulses once.
